// File: rtl/cu_wg_tracker_if.sv
// Handshake bundle between the CTA allocator and cu_wg_tracker.
// master: allocator / CU side; slave: the tracker.
interface cu_wg_tracker_if #(
    parameter int SLOT_W     = 3,
    parameter int WF_CNT_W   = 4,
    parameter int WG_ID_W    = 16,
    parameter int DONE_PORTS = 2,
    parameter int TAG_W      = SLOT_W + WF_CNT_W
);
    logic                        alloc_valid_i;
    logic                        alloc_ready_o;
    logic [WG_ID_W-1:0]          alloc_wg_id_i;
    logic [WF_CNT_W-1:0]         alloc_wf_count_i;
    logic                        disp_valid_o;
    logic                        disp_ready_i;
    logic [TAG_W-1:0]            disp_tag_o;
    logic [DONE_PORTS-1:0]       done_valid_i;
    logic [DONE_PORTS*TAG_W-1:0] done_tag_i;
    logic                        wg_done_valid_o;
    logic [WG_ID_W-1:0]          wg_done_wg_id_o;
    logic                        wg_done_ack_i;

    modport master (
        output alloc_valid_i, alloc_wg_id_i, alloc_wf_count_i,
        output disp_ready_i, done_valid_i, done_tag_i, wg_done_ack_i,
        input  alloc_ready_o, disp_valid_o, disp_tag_o,
        input  wg_done_valid_o, wg_done_wg_id_o
    );

    modport slave (
        input  alloc_valid_i, alloc_wg_id_i, alloc_wf_count_i,
        input  disp_ready_i, done_valid_i, done_tag_i, wg_done_ack_i,
        output alloc_ready_o, disp_valid_o, disp_tag_o,
        output wg_done_valid_o, wg_done_wg_id_o
    );
endinterface

// File: rtl/cu_wg_tracker.sv
// Per-CU workgroup tracker: allocates workgroup slots, issues per-wavefront
// dispatch tags, counts wavefront completions over DONE_PORTS parallel ports
// and reports finished workgroups through a round-robin arbiter.
// Optional macro CU_WG_TRACKER_PERF_EN adds dispatch-stall and finished-WG
// performance counters.
module cu_wg_tracker #(
    parameter int NUM_SLOTS  = 8,
    parameter int SLOT_W     = 3,
    parameter int WF_CNT_W   = 4,
    parameter int WG_ID_W    = 16,
    parameter int DONE_PORTS = 2,
    parameter int TAG_W      = SLOT_W + WF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cu_wg_tracker_if.slave       bus,
    output logic [NUM_SLOTS-1:0] busy_slots_o,
    output logic                 err_o
`ifdef CU_WG_TRACKER_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt_o,
    output logic [31:0]          perf_wg_cnt_o
`endif
);

    localparam int HIT_W = $clog2(DONE_PORTS + 1);
    // Compare width wide enough for both the count and the per-cycle hits.
    localparam int CW    = ((WF_CNT_W > HIT_W) ? WF_CNT_W : HIT_W) + 1;

    typedef enum logic {D_IDLE, D_ISSUE} dstate_t;

    dstate_t dstate, dstate_nxt;

    logic [NUM_SLOTS-1:0] used, complete;
    logic [WF_CNT_W-1:0]  outstanding [NUM_SLOTS];
    logic [WG_ID_W-1:0]   wg_ids      [NUM_SLOTS];

    logic [SLOT_W-1:0]    disp_slot;
    logic [WF_CNT_W-1:0]  remain;
    logic                 disp_valid, disp_fire;

    logic                 run;
    logic                 free_found;
    logic [SLOT_W-1:0]    free_slot;
    logic                 alloc_ready, accept;

    logic [HIT_W-1:0]     hits    [NUM_SLOTS];
    logic [WF_CNT_W-1:0]  out_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] under;
    logic                 stray;
    logic [DONE_PORTS-1:0] unused_wf_bits;

    logic                 rep_valid;
    logic [WG_ID_W-1:0]   rep_id;
    logic [SLOT_W-1:0]    rep_slot, last_grant, rr_idx, grant_slot;
    logic                 grant_found, grant, ack;
    logic                 err;

    // Hold alloc_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Lowest-index free slot.
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!used[s]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(s);
            end
        end
    end

    assign alloc_ready = run && (dstate == D_IDLE) && free_found;
    assign accept      = bus.alloc_valid_i && alloc_ready;

    // Dispatch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dstate <= D_IDLE;
        else        dstate <= dstate_nxt;
    end

    // Dispatch FSM next state and outputs; zero-wavefront workgroups never issue.
    always_comb begin
        dstate_nxt = dstate;
        disp_valid = 1'b0;
        disp_fire  = 1'b0;
        case (dstate)
            D_IDLE: begin
                if (accept && (bus.alloc_wf_count_i != '0)) dstate_nxt = D_ISSUE;
            end
            D_ISSUE: begin
                disp_valid = 1'b1;
                disp_fire  = bus.disp_ready_i;
                if (bus.disp_ready_i && (remain == WF_CNT_W'(1))) dstate_nxt = D_IDLE;
            end
            default: dstate_nxt = D_IDLE;
        endcase
    end

    // Dispatch datapath: latch the slot on accept, count down issued wavefronts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_slot <= '0;
            remain    <= '0;
        end else if (accept) begin
            disp_slot <= free_slot;
            remain    <= bus.alloc_wf_count_i;
        end else if (disp_fire) begin
            remain    <= remain - WF_CNT_W'(1);
        end
    end

    // Per-slot completion hits this cycle; dones to unused slots are flagged.
    always_comb begin
        stray = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) hits[s] = '0;
        for (int k = 0; k < DONE_PORTS; k++) begin
            unused_wf_bits[k] = ^bus.done_tag_i[k*TAG_W +: WF_CNT_W];
            if (bus.done_valid_i[k]) begin
                if (used[bus.done_tag_i[k*TAG_W + WF_CNT_W +: SLOT_W]])
                    hits[bus.done_tag_i[k*TAG_W + WF_CNT_W +: SLOT_W]] =
                        hits[bus.done_tag_i[k*TAG_W + WF_CNT_W +: SLOT_W]] + HIT_W'(1);
                else
                    stray = 1'b1;
            end
        end
    end

    // Next outstanding count per slot, saturating at zero on over-completion.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            under[s]   = CW'(hits[s]) > CW'(outstanding[s]);
            out_nxt[s] = under[s] ? '0
                                  : WF_CNT_W'(CW'(outstanding[s]) - CW'(hits[s]));
        end
    end

    // Slot table: allocation fills a free slot, ack frees the reported one,
    // otherwise used slots count completions and flag themselves complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used     <= '0;
            complete <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                outstanding[s] <= '0;
                wg_ids[s]      <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (accept && (free_slot == SLOT_W'(s))) begin
                    used[s]        <= 1'b1;
                    complete[s]    <= 1'b0;
                    outstanding[s] <= bus.alloc_wf_count_i;
                    wg_ids[s]      <= bus.alloc_wg_id_i;
                end else if (ack && (rep_slot == SLOT_W'(s))) begin
                    used[s]     <= 1'b0;
                    complete[s] <= 1'b0;
                end else if (used[s]) begin
                    outstanding[s] <= out_nxt[s];
                    if (out_nxt[s] == '0) complete[s] <= 1'b1;
                end
            end
        end
    end

    // Round-robin pick among complete slots, starting after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_slot  = '0;
        rr_idx      = '0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            rr_idx = last_grant + SLOT_W'(i);
            if (!grant_found && complete[rr_idx]) begin
                grant_found = 1'b1;
                grant_slot  = rr_idx;
            end
        end
    end

    assign grant = !rep_valid && grant_found;
    assign ack   = rep_valid && bus.wg_done_ack_i;

    // Done report register: hold ID until ack; grant only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_valid  <= 1'b0;
            rep_id     <= '0;
            rep_slot   <= '0;
            last_grant <= SLOT_W'(NUM_SLOTS - 1);
        end else if (grant) begin
            rep_valid  <= 1'b1;
            rep_id     <= wg_ids[grant_slot];
            rep_slot   <= grant_slot;
            last_grant <= grant_slot;
        end else if (ack) begin
            rep_valid  <= 1'b0;
        end
    end

    // Sticky protocol error: stray dones and over-completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err | stray | (|under);
    end

`ifdef CU_WG_TRACKER_PERF_EN
    logic [31:0] stall_cnt, wg_cnt;

    // Count stalled dispatch cycles and acknowledged workgroups (wrapping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            wg_cnt    <= '0;
        end else begin
            if (disp_valid && !bus.disp_ready_i) stall_cnt <= stall_cnt + 32'd1;
            if (ack)                             wg_cnt    <= wg_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt;
    assign perf_wg_cnt_o    = wg_cnt;
`endif

    assign bus.alloc_ready_o   = alloc_ready;
    assign bus.disp_valid_o    = disp_valid;
    assign bus.disp_tag_o      = disp_valid ? {disp_slot, remain - WF_CNT_W'(1)} : '0;
    assign bus.wg_done_valid_o = rep_valid;
    assign bus.wg_done_wg_id_o = rep_id;
    assign busy_slots_o        = used;
    assign err_o               = err;

endmodule

// File: tb/tb_cu_wg_tracker.sv
// Directed self-checking bench for cu_wg_tracker.
module tb_cu_wg_tracker;

    logic       clk;
    logic       rst_n;
    logic [7:0] busy;
    logic       err;
    int         total = 0;
    int         bad   = 0;

`ifdef CU_WG_TRACKER_PERF_EN
    logic [31:0] perf_stall, perf_wg;
`endif

    cu_wg_tracker_if #(.SLOT_W(3), .WF_CNT_W(4), .WG_ID_W(16), .DONE_PORTS(2)) bus ();

    cu_wg_tracker #(
        .NUM_SLOTS(8), .SLOT_W(3), .WF_CNT_W(4), .WG_ID_W(16), .DONE_PORTS(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy_slots_o (busy),
        .err_o        (err)
`ifdef CU_WG_TRACKER_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall),
        .perf_wg_cnt_o    (perf_wg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_done(input logic v0, input logic [6:0] t0,
                            input logic v1, input logic [6:0] t1);
        bus.done_valid_i = {v1, v0};
        bus.done_tag_i   = {t1, t0};
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_wg_id_i    = '0;
        bus.alloc_wf_count_i = '0;
        bus.disp_ready_i     = 1'b1;
        bus.wg_done_ack_i    = 1'b0;
        set_done(0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Allocate one workgroup and drain its dispatch (disp_ready held high).
    task automatic alloc_one(input logic [15:0] id, input logic [3:0] cnt, input int slot);
        chk("alloc_rdy", bus.alloc_ready_o, 1);
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_wg_id_i    = id;
        bus.alloc_wf_count_i = cnt;
        tick();
        bus.alloc_valid_i = 1'b0;
        if (cnt != 0) begin
            chk("alloc_tag", bus.disp_tag_o, (slot << 4) | (cnt - 1));
            repeat (cnt) tick();
        end
    endtask

    // Wait (bounded) for a report, check its ID, ack it for one cycle.
    task automatic expect_report(input logic [15:0] id, input string tag);
        int n = 0;
        while (!bus.wg_done_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, bus.wg_done_valid_o, 1);
        chk({tag, "_id"}, bus.wg_done_wg_id_o, id);
        bus.wg_done_ack_i = 1'b1;
        tick();
        bus.wg_done_ack_i = 1'b0;
        chk({tag, "_drop"}, bus.wg_done_valid_o, 0);
    endtask

    initial begin
        // ---- reset state ----
        rst_n                = 1'b0;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_wg_id_i    = '0;
        bus.alloc_wf_count_i = '0;
        bus.disp_ready_i     = 1'b1;
        bus.wg_done_ack_i    = 1'b0;
        set_done(0, 0, 0, 0);
        tick();
        chk("rst_rdy", bus.alloc_ready_o, 0);
        chk("rst_dvld", bus.disp_valid_o, 0);
        chk("rst_tag", bus.disp_tag_o, 0);
        chk("rst_wvld", bus.wg_done_valid_o, 0);
        chk("rst_wid", bus.wg_done_wg_id_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", bus.alloc_ready_o, 1);

        // ---- 1: single WG, three wavefronts ----
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_wg_id_i    = 16'h0012;
        bus.alloc_wf_count_i = 4'd3;
        tick();
        bus.alloc_valid_i = 1'b0;
        chk("t1_dvld0", bus.disp_valid_o, 1);
        chk("t1_tag0", bus.disp_tag_o, 7'h02);
        chk("t1_busy", busy, 8'h01);
        chk("t1_rdy_issue", bus.alloc_ready_o, 0);
        tick();
        chk("t1_tag1", bus.disp_tag_o, 7'h01);
        tick();
        chk("t1_tag2", bus.disp_tag_o, 7'h00);
        tick();
        chk("t1_dvld_end", bus.disp_valid_o, 0);
        chk("t1_rdy_idle", bus.alloc_ready_o, 1);
        set_done(1, 7'h02, 1, 7'h01);
        tick();
        set_done(1, 7'h00, 0, 0);
        tick();
        set_done(0, 0, 0, 0);
        chk("t1_wvld_early", bus.wg_done_valid_o, 0);
        tick();
        chk("t1_wvld", bus.wg_done_valid_o, 1);
        chk("t1_wid", bus.wg_done_wg_id_o, 16'h0012);
        tick();
        chk("t1_wvld_hold", bus.wg_done_valid_o, 1);
        chk("t1_wid_hold", bus.wg_done_wg_id_o, 16'h0012);
        bus.wg_done_ack_i = 1'b1;
        tick();
        bus.wg_done_ack_i = 1'b0;
        chk("t1_wvld_ack", bus.wg_done_valid_o, 0);
        chk("t1_busy_free", busy, 0);
        chk("t1_err", err, 0);

        // ---- 2: fill all slots, free slot 5, reallocate ----
        do_reset();
        for (int i = 0; i < 8; i++) alloc_one(16'h0100 + 16'(i), 4'd1, i);
        chk("t2_busy_full", busy, 8'hFF);
        chk("t2_rdy_full", bus.alloc_ready_o, 0);
        set_done(1, 7'h50, 0, 0);
        tick();
        set_done(0, 0, 0, 0);
        tick();
        chk("t2_wvld", bus.wg_done_valid_o, 1);
        chk("t2_wid", bus.wg_done_wg_id_o, 16'h0105);
        bus.wg_done_ack_i    = 1'b1;
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_wg_id_i    = 16'h0155;
        bus.alloc_wf_count_i = 4'd1;
        chk("t2_rdy_ackcyc", bus.alloc_ready_o, 0);
        tick();
        bus.wg_done_ack_i = 1'b0;
        chk("t2_busy_freed", busy, 8'hDF);
        chk("t2_rdy_after", bus.alloc_ready_o, 1);
        tick();
        bus.alloc_valid_i = 1'b0;
        chk("t2_realloc_tag", bus.disp_tag_o, 7'h50);
        chk("t2_busy_refull", busy, 8'hFF);
        tick();

        // ---- 3: both ports hit slot 1 in one cycle ----
        do_reset();
        alloc_one(16'h0030, 4'd1, 0);
        alloc_one(16'h0031, 4'd2, 1);
        set_done(1, 7'h11, 1, 7'h10);
        tick();
        set_done(0, 0, 0, 0);
        chk("t3_wvld_early", bus.wg_done_valid_o, 0);
        chk("t3_err", err, 0);
        tick();
        chk("t3_wvld", bus.wg_done_valid_o, 1);
        chk("t3_wid", bus.wg_done_wg_id_o, 16'h0031);
        bus.wg_done_ack_i = 1'b1;
        tick();
        bus.wg_done_ack_i = 1'b0;
        chk("t3_busy", busy, 8'h01);
        tick();
        tick();
        chk("t3_single", bus.wg_done_valid_o, 0);
        chk("t3_err_end", err, 0);

        // ---- 4: round-robin order ----
        do_reset();
        for (int i = 0; i < 8; i++) alloc_one(16'h0040 + 16'(i), 4'd1, i);
        set_done(1, 7'h00, 0, 0);
        tick();
        set_done(0, 0, 0, 0);
        tick();
        chk("t4_first_id", bus.wg_done_wg_id_o, 16'h0040);
        set_done(1, 7'h60, 1, 7'h30);
        tick();
        set_done(1, 7'h20, 0, 0);
        tick();
        set_done(0, 0, 0, 0);
        tick();
        chk("t4_hold_id", bus.wg_done_wg_id_o, 16'h0040);
        expect_report(16'h0040, "t4_r0");
        expect_report(16'h0042, "t4_r2");
        expect_report(16'h0043, "t4_r3");
        expect_report(16'h0046, "t4_r6");
        set_done(1, 7'h10, 1, 7'h70);
        tick();
        set_done(0, 0, 0, 0);
        expect_report(16'h0047, "t4_r7");
        expect_report(16'h0041, "t4_r1");
        chk("t4_busy", busy, 8'h30);
        chk("t4_err", err, 0);
`ifdef CU_WG_TRACKER_PERF_EN
        chk("t4_perf_wg", perf_wg, 6);
`endif

        // ---- 5: stray done, zero-wavefront WG ----
        do_reset();
        set_done(1, 7'h40, 0, 0);
        tick();
        set_done(0, 0, 0, 0);
        chk("t5_err", err, 1);
        tick();
        tick();
        chk("t5_no_report", bus.wg_done_valid_o, 0);
        chk("t5_err_sticky", err, 1);
        alloc_one(16'h0077, 4'd0, 0);
        chk("t5_no_disp", bus.disp_valid_o, 0);
        chk("t5_busy", busy, 8'h01);
        tick();
        chk("t5_wvld_early", bus.wg_done_valid_o, 0);
        tick();
        chk("t5_wvld", bus.wg_done_valid_o, 1);
        chk("t5_wid", bus.wg_done_wg_id_o, 16'h0077);
        expect_report(16'h0077, "t5_r");
        chk("t5_err_end", err, 1);

        // ---- 6: dispatch stall, then reset mid-dispatch ----
        do_reset();
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_wg_id_i    = 16'h0066;
        bus.alloc_wf_count_i = 4'd4;
        tick();
        bus.alloc_valid_i = 1'b0;
        chk("t6_tag0", bus.disp_tag_o, 7'h03);
        tick();
        chk("t6_tag1", bus.disp_tag_o, 7'h02);
        bus.disp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_stall_vld", bus.disp_valid_o, 1);
            chk("t6_stall_tag", bus.disp_tag_o, 7'h02);
        end
        bus.disp_ready_i = 1'b1;
`ifdef CU_WG_TRACKER_PERF_EN
        chk("t6_perf_stall", perf_stall, 5);
`endif
        tick();
        chk("t6_tag2", bus.disp_tag_o, 7'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dvld", bus.disp_valid_o, 0);
        chk("t6_rst_tag", bus.disp_tag_o, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wvld", bus.wg_done_valid_o, 0);
        chk("t6_rst_rdy", bus.alloc_ready_o, 0);
`ifdef CU_WG_TRACKER_PERF_EN
        chk("t6_rst_perf", perf_stall, 0);
        chk("t6_rst_perfwg", perf_wg, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_rdy_after", bus.alloc_ready_o, 1);
        chk("t6_dvld_after", bus.disp_valid_o, 0);
        chk("t6_err_after", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
